// File: rtl/sched_dispatch_v2.sv
// sched_dispatch_v2: walks task blocks in program RAM, applies fence rules, streams words to cores
module sched_dispatch_v2 #(
    parameter int PROG_DEPTH  = 1024,
    parameter int INSTR_SIZE  = 16,
    parameter int CORE_NUM    = 16,
    parameter int BLOCK_WORDS = 16,
    parameter int IFNUM_W     = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [INSTR_SIZE-1:0]         prog_wdata,
    input  logic                          start,
    input  logic [$clog2(PROG_DEPTH)-1:0] start_addr,
    input  logic [CORE_NUM-1:0]           core_ready,
    output logic [INSTR_SIZE-1:0]         msg_data,
    output logic [1:0]                    msg_kind,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          fence_stall
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int BW = $clog2(BLOCK_WORDS);
    localparam int OW = BW + IFNUM_W;

    typedef enum logic [2:0] {IDLE, HDR, CHECK, STREAM, NEXT, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [INSTR_SIZE-1:0] mem [PROG_DEPTH];
    logic [INSTR_SIZE-1:0] rd;
    logic [AW-1:0]         ptr, ra;
    logic                  ren;
    logic [OW-1:0]         off, last_off;
    logic [IFNUM_W-1:0]    if_num;
    logic [1:0]            fence;
    logic                  last_task;
    logic [CORE_NUM-1:0]   last_mask, mask;
    logic                  pend;
    logic [1:0]            pend_kind, issue_kind, push_kind;
    logic                  go, chk_go, issue, push, pop, room;
    logic [INSTR_SIZE-1:0] d0, d1;
    logic [1:0]            k0, k1, cnt, slot;

    assign mask       = rd[CORE_NUM-1:0];
    assign last_off   = {if_num, {BW{1'b1}}};
    assign issue_kind = off == OW'(2) ? 2'd1 : off < OW'(BLOCK_WORDS) ? 2'd2 : 2'd3;
    assign push       = pend | chk_go;
    assign push_kind  = pend ? pend_kind : 2'd0;
    assign msg_valid  = cnt != 2'd0;
    assign pop        = msg_valid & msg_ready;
    assign slot       = cnt - 2'(pop);
    assign room       = 3'(cnt) + 3'(pend) <= 3'd1 + 3'(pop);
    assign msg_data   = d0;
    assign msg_kind   = k0;
    assign busy       = state != IDLE && state != DONE;
    assign done       = state == DONE;

    // program RAM: host writes only while idle, reads have one cycle of latency
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
        if (ren) rd <= mem[ra];
    end

    // next state, RAM read requests and fence evaluation
    always_comb begin
        state_nxt   = state;
        ren         = 1'b0;
        ra          = ptr;
        issue       = 1'b0;
        chk_go      = 1'b0;
        fence_stall = 1'b0;
        go = fence == 2'd2 ? &core_ready :
             ~|(mask & ~core_ready) && (fence != 2'd1 || ~|(last_mask & ~core_ready));
        unique case (state)
            IDLE: if (start && !prog_we) begin
                ren       = 1'b1;
                ra        = start_addr;
                state_nxt = HDR;
            end
            HDR: begin
                ren       = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                fence_stall = !go;
                chk_go      = go && cnt == 2'(pop);
                issue       = chk_go;
            end
            STREAM: issue = room;
            NEXT: begin
                ren       = 1'b1;
                state_nxt = HDR;
            end
            DRAIN: if (!pend && cnt == 2'(pop)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (issue) begin
            ren       = 1'b1;
            state_nxt = off == last_off ? (last_task ? DRAIN : NEXT) : STREAM;
        end
    end

    // control state: read pointer, word offset in task, captured header, in-flight read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            off       <= '0;
            if_num    <= '0;
            fence     <= '0;
            last_task <= 1'b0;
            last_mask <= '0;
            pend      <= 1'b0;
            pend_kind <= '0;
        end else begin
            state <= state_nxt;
            pend  <= issue;
            if (ren) ptr <= ra + AW'(1);
            if (issue) begin
                pend_kind <= issue_kind;
                off       <= off + OW'(1);
            end
            if (state == HDR) begin
                if_num    <= rd[IFNUM_W-1:0];
                fence     <= rd[7:6];
                last_task <= rd[15];
                off       <= OW'(2);
            end
            if (chk_go) last_mask <= mask;
        end
    end

    // two-entry output skid buffer hiding the RAM read latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0  <= '0;
            d1  <= '0;
            k0  <= '0;
            k1  <= '0;
            cnt <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            if (pop) begin
                d0 <= d1;
                k0 <= k1;
            end
            if (push && slot == 2'd0) begin
                d0 <= rd;
                k0 <= push_kind;
            end
            if (push && slot == 2'd1) begin
                d1 <= rd;
                k1 <= push_kind;
            end
        end
    end
endmodule

// File: tb/tb_sched_dispatch_v2.sv
// tb_sched_dispatch_v2: directed tests against a task-walking reference model
module tb_sched_dispatch_v2;
    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        start;
    logic [9:0]  start_addr;
    logic [15:0] core_ready;
    logic [15:0] msg_data;
    logic [1:0]  msg_kind;
    logic        msg_valid;
    logic        msg_ready;
    logic        busy;
    logic        done;
    logic        fence_stall;

    logic        bp = 1'b0;
    logic        tog = 1'b0;
    logic [15:0] img [1024];
    ent_t        exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          nx = 0;
    logic        due = 1'b0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_d;
    logic [1:0]  prev_k;

    sched_dispatch_v2 dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .start_addr(start_addr),
        .core_ready(core_ready), .msg_data(msg_data), .msg_kind(msg_kind),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy), .done(done),
        .fence_stall(fence_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) #1 tog = ~tog;
    assign msg_ready = !bp | tog;

    // reference model: walk task headers and list every word the bus must carry
    task automatic build(input int a0);
        int a;
        int n;
        logic [15:0] h;
        ent_t e;
        a = a0;
        for (int t = 0; t < 64; t++) begin
            h = img[a];
            n = 16 * (int'(h[5:0]) + 1);
            for (int w = 1; w < n; w++) begin
                e.d = img[(a + w) % 1024];
                e.k = w == 1 ? 2'd0 : w == 2 ? 2'd1 : w < 16 ? 2'd2 : 2'd3;
                exp_q.push_back(e);
            end
            a = (a + n) % 1024;
            if (h[15]) break;
        end
    endtask

    // per-cycle checker: transferred words, stall stability, done timing
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
            due = 1'b0;
        end else begin
            total++;
            if (done !== due) begin
                bad++;
                $display("FAIL done_pulse got=%0b want=%0b at %0t", done, due, $time);
            end
            due = 1'b0;
            if (stall_prev) begin
                total++;
                if (msg_valid !== 1'b1 || msg_data !== prev_d || msg_kind !== prev_k) begin
                    bad++;
                    $display("FAIL hold got v=%0b d=%h k=%0d want v=1 d=%h k=%0d", msg_valid, msg_data, msg_kind, prev_d, prev_k);
                end
            end
            if (msg_valid && msg_ready) begin
                ent_t e;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word got d=%h k=%0d want none", msg_data, msg_kind);
                end else begin
                    e = exp_q.pop_front();
                    if (msg_data !== e.d || msg_kind !== e.k) begin
                        bad++;
                        $display("FAIL word%0d got d=%h k=%0d want d=%h k=%0d", nx, msg_data, msg_kind, e.d, e.k);
                    end
                    if (exp_q.size() == 0) due = 1'b1;
                end
                nx++;
            end
            stall_prev = msg_valid && !msg_ready;
            prev_d = msg_data;
            prev_k = msg_kind;
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = 10'(a);
        prog_wdata = d;
        img[a] = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic blk(input int base, input logic [15:0] h, input logic [15:0] m, input logic [15:0] r, input logic [15:0] db);
        for (int i = 0; i < 16; i++)
            wr(base + i, i == 0 ? h : i == 1 ? m : i == 2 ? r : db + 16'(i));
    endtask

    task automatic go_start(input int a);
        nx = 0;
        start = 1'b1;
        start_addr = 10'(a);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int words);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c >= 3000) begin
            bad++;
            $display("FAIL %s_timeout got no done want done", nm);
        end
        chk({nm, "_words"}, nx, words);
        chk({nm, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_stall(input string nm);
        int c;
        c = 0;
        while (fence_stall !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_seen"}, int'(fence_stall), 1);
    endtask

    task automatic hold_stall(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({nm, "_stalled"}, {30'd0, fence_stall, msg_valid}, 2);
        end
    endtask

    task automatic latency(input string nm, input logic [15:0] d0);
        int c;
        c = 0;
        while (msg_valid !== 1'b1 && c < 6) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c > 3) begin
            bad++;
            $display("FAIL %s_latency got=%0d want<=3", nm, c);
        end
        chk({nm, "_first_data"}, int'(msg_data), int'(d0));
        chk({nm, "_first_kind"}, int'(msg_kind), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k3;
        reset = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_wdata = '0;
        start = 1'b0;
        start_addr = '0;
        core_ready = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(msg_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stall", int'(fence_stall), 0);
        chk("rst_data", int'(msg_data), 0);
        chk("rst_kind", int'(msg_kind), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        blk(0, 16'h8002, 16'h000F, 16'h0003, 16'h1000);
        for (int i = 16; i < 48; i++) wr(i, 16'h2000 + 16'(i));
        blk(16'h100, 16'h0000, 16'h0002, 16'h0001, 16'h3000);
        blk(16'h110, 16'h8080, 16'h0001, 16'h0001, 16'h3100);
        blk(16'h200, 16'h0000, 16'h00F0, 16'h00F0, 16'h4000);
        blk(16'h210, 16'h8040, 16'h000F, 16'h000F, 16'h4100);

        // single task, full throughput
        build(0);
        chk("model_len", exp_q.size(), 47);
        chk("model_w0", int'(exp_q[0]), int'({16'h000F, 2'd0}));
        chk("model_w1", int'(exp_q[1]), int'({16'h0003, 2'd1}));
        chk("model_w14_kind", int'(exp_q[14].k), 2);
        chk("model_w15", int'(exp_q[15]), int'({16'h2010, 2'd3}));
        go_start(0);
        @(negedge clk);
        chk("t1_busy", int'(busy), 1);
        latency("t1", 16'h000F);
        wait_done("t1", 47);

        // same program with alternating backpressure
        bp = 1'b1;
        build(0);
        go_start(0);
        wait_done("t2", 47);
        bp = 1'b0;

        // asynchronous reset in the middle of the instruction stream
        build(0);
        go_start(0);
        for (int c = 0; c < 200 && nx < 20; c++) @(negedge clk);
        chk("t3_midway", int'(nx >= 20), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        chk("t3_valid", int'(msg_valid), 0);
        chk("t3_busy", int'(busy), 0);
        chk("t3_done", int'(done), 0);
        chk("t3_stall", int'(fence_stall), 0);
        chk("t3_data", int'(msg_data), 0);
        chk("t3_kind", int'(msg_kind), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        build(0);
        go_start(0);
        latency("t3r", 16'h000F);
        wait_done("t3r", 47);

        // release fence waits for every core to be idle
        core_ready = 16'hFFFE;
        build(16'h100);
        chk("model_rel_len", exp_q.size(), 30);
        go_start(16'h100);
        wait_stall("t4");
        hold_stall("t4", 4);
        chk("t4_task1_words", nx, 15);
        @(posedge clk);
        #1 core_ready = 16'hFFFF;
        latency("t4", 16'h0001);
        wait_done("t4", 30);

        // acquire fence waits for the previous task's cores
        build(16'h200);
        go_start(16'h200);
        for (int c = 0; c < 50 && nx < 1; c++) @(negedge clk);
        @(posedge clk);
        #1 core_ready = 16'hFF0F;
        wait_stall("t5");
        chk("t5_task1_words", nx, 15);
        @(posedge clk);
        #1 core_ready = 16'hFF7F;
        hold_stall("t5", 3);
        @(posedge clk);
        #1 core_ready = 16'hFFFF;
        latency("t5", 16'h000F);
        wait_done("t5", 30);

        // program wrapping past the top of RAM, tasks without instructions
        blk(16'h3F0, 16'h0000, 16'h0011, 16'h0022, 16'h5000);
        blk(0, 16'h8000, 16'h0033, 16'h0044, 16'h5100);
        build(16'h3F0);
        chk("model_wrap_len", exp_q.size(), 30);
        k3 = 0;
        foreach (exp_q[i]) if (exp_q[i].k == 2'd3) k3++;
        chk("model_wrap_kind3", k3, 0);
        chk("model_wrap_w15", int'(exp_q[15]), int'({16'h0033, 2'd0}));
        go_start(16'h3F0);
        wait_done("t6", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
